// File: rtl/montgomery_arbiter.sv
// Round-robin arbiter sharing one montgomery multiplier core between two requesters.
// Latches the winner's operands, sequences core reset/start/done and guards with a watchdog.
module montgomery_arbiter #(
  parameter int unsigned N       = 1024,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic         req1,
  input  logic [N-1:0] a0,
  input  logic [N-1:0] b0,
  input  logic [N-1:0] a1,
  input  logic [N-1:0] b1,
  input  logic [N-1:0] m,
  output logic         gnt0,
  output logic         gnt1,
  output logic         done0,
  output logic         done1,
  output logic         err,
  output logic [N-1:0] result,
  output logic         busy,
  output logic         mul_resetn,
  output logic         mul_start,
  output logic [N-1:0] mul_a,
  output logic [N-1:0] mul_b,
  output logic [N-1:0] mul_m,
  input  logic [N-1:0] mul_result,
  input  logic         mul_done
);

  localparam int unsigned    CntW   = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWait,
    StResp
  } state_e;

  state_e            state_q;
  logic              owner_q;
  logic              last_q;
  logic [CntW-1:0]   cnt_q;
  logic              pick1;

  // Under contention the requester not served last wins.
  always_comb begin
    pick1 = 1'b0;
    if (req0 && req1) begin
      pick1 = ~last_q;
    end else begin
      pick1 = req1;
    end
  end

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      err        <= 1'b0;
      result     <= '0;
      mul_resetn <= 1'b0;
      mul_start  <= 1'b0;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_m      <= '0;
    end else begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      mul_start <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req0 || req1) begin
            owner_q    <= pick1;
            mul_a      <= pick1 ? a1 : a0;
            mul_b      <= pick1 ? b1 : b0;
            mul_m      <= m;
            gnt0       <= ~pick1;
            gnt1       <= pick1;
            mul_start  <= 1'b1;
            mul_resetn <= 1'b1;
            state_q    <= StStart;
          end
        end
        StStart: begin
          cnt_q   <= '0;
          state_q <= StWait;
        end
        StWait: begin
          cnt_q <= cnt_q + 1'b1;
          // A completion on the final watchdog count still counts as success.
          if (mul_done || (cnt_q == CntMax)) begin
            result     <= mul_done ? mul_result : '0;
            err        <= ~mul_done;
            done0      <= ~owner_q;
            done1      <= owner_q;
            mul_resetn <= 1'b0;
            state_q    <= StResp;
          end
        end
        StResp: begin
          err     <= 1'b0;
          last_q  <= owner_q;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_arbiter.sv
// Scoreboard bench for montgomery_arbiter with a behavioural multiplier core model.
module tb_montgomery_arbiter;

  localparam int unsigned N  = 8;
  localparam int unsigned TO = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [N-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0, m = '0;
  logic         gnt0, gnt1, done0, done1, err, busy, mul_resetn, mul_start;
  logic [N-1:0] result, mul_a, mul_b, mul_m;
  logic [N-1:0] mul_result;
  logic         mul_done;

  montgomery_arbiter #(.N(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .m(m),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err(err),
    .result(result), .busy(busy), .mul_resetn(mul_resetn), .mul_start(mul_start),
    .mul_a(mul_a), .mul_b(mul_b), .mul_m(mul_m),
    .mul_result(mul_result), .mul_done(mul_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Core model: mul_done rises core_lat cycles after the mul_start cycle (0 = never),
  // and stays high until mul_resetn is dropped.
  int core_lat = 0;
  int mcnt = 0;
  logic         mdone = 1'b0;
  logic [N-1:0] mres = '0;
  assign mul_done   = mdone;
  assign mul_result = mres;

  function automatic logic [N-1:0] modmul(input logic [N-1:0] x, y, mm);
    int unsigned p;
    p = (int'(x) * int'(y)) % int'(mm);
    return N'(p);
  endfunction

  always @(posedge clk) begin
    if (!mul_resetn) begin
      mdone <= 1'b0;
      mcnt  <= 0;
    end else if (mul_start) begin
      mres <= modmul(mul_a, mul_b, mul_m);
      if (core_lat == 1) mdone <= 1'b1;
      else if (core_lat > 1) mcnt <= core_lat - 1;
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) mdone <= 1'b1;
    end
  end

  typedef struct packed {logic [1:0] who; logic [N-1:0] a; logic [N-1:0] b; logic [N-1:0] m;} gnt_t;
  typedef struct packed {logic [1:0] who; logic [N-1:0] res; logic err;} rsp_t;
  gnt_t gq[$];
  rsp_t rq[$];

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: compares every grant and every done pulse against the queued expectations.
  always @(negedge clk) begin
    gnt_t ge;
    rsp_t re;
    if (gnt0 || gnt1) begin
      if (gq.size() == 0) begin
        check("unexpected_gnt", {gnt1, gnt0}, 2'b00);
      end else begin
        ge = gq.pop_front();
        check("gnt_who", {gnt1, gnt0}, ge.who);
        check("mul_a", mul_a, ge.a);
        check("mul_b", mul_b, ge.b);
        check("mul_m", mul_m, ge.m);
        check("start_resetn", {mul_start, mul_resetn}, 2'b11);
      end
    end
    if (done0 || done1) begin
      if (rq.size() == 0) begin
        check("unexpected_done", {done1, done0}, 2'b00);
      end else begin
        re = rq.pop_front();
        check("done_who", {done1, done0}, re.who);
        check("result", result, re.res);
        check("err", err, re.err);
        check("resp_resetn", mul_resetn, 1'b0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctl"}, {gnt0, gnt1, done0, done1, err, busy, mul_resetn, mul_start}, 8'h00);
    check({name, "_result"}, result, '0);
    check({name, "_ops"}, {mul_a, mul_b, mul_m}, '0);
  endtask

  task automatic wait_done(input string name, input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      if (done0 || done1) begin
        at = cyc;
        break;
      end
      tick();
    end
    if (at < 0) check({name, "_done_seen"}, {31'd0, done0 | done1}, 1);
  endtask

  // Issue one request from an idle arbiter and check grant/done timing.
  task automatic single(input string name, input bit who, input logic [N-1:0] a, b, mm,
                        input int lat, input logic [N-1:0] exp_res, input bit exp_err,
                        input int exp_lat);
    int g, d;
    core_lat = lat;
    if (who) begin a1 = a; b1 = b; req1 = 1'b1; end
    else     begin a0 = a; b0 = b; req0 = 1'b1; end
    m = mm;
    gq.push_back('{who ? 2'b10 : 2'b01, a, b, mm});
    rq.push_back('{who ? 2'b10 : 2'b01, exp_res, exp_err});
    tick();
    check({name, "_gnt_next_cycle"}, who ? gnt1 : gnt0, 1'b1);
    g = cyc;
    req0 = 1'b0;
    req1 = 1'b0;
    wait_done(name, 200, d);
    if (d >= 0) check({name, "_done_latency"}, d - g, exp_lat);
    tick();
    check({name, "_idle_after"}, busy, 1'b0);
  endtask

  initial begin
    int g, d, d0, d1, ng, nd, lastg;

    // Reset state.
    reset = 1'b1;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();
    check_all_zero("post_reset");

    // Contention straight from reset: requester 0 first, then 1.
    core_lat = 3;
    a0 = 8'd2; b0 = 8'd3; a1 = 8'd4; b1 = 8'd5; m = 8'd11;
    gq.push_back('{2'b01, 8'd2, 8'd3, 8'd11});
    gq.push_back('{2'b10, 8'd4, 8'd5, 8'd11});
    rq.push_back('{2'b01, 8'd6, 1'b0});
    rq.push_back('{2'b10, 8'd9, 1'b0});
    req0 = 1'b1; req1 = 1'b1;
    d0 = -1; d1 = -1;
    for (int i = 0; i < 100 && (d0 < 0 || d1 < 0); i++) begin
      tick();
      if (gnt0) req0 = 1'b0;
      if (gnt1) req1 = 1'b0;
      if (done0 && d0 < 0) d0 = cyc;
      if (done1 && d1 < 0) d1 = cyc;
    end
    check("contention_both_done", {d0 >= 0, d1 >= 0}, 2'b11);
    check("contention_order", d0 < d1, 1'b1);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();

    // Single op: 3*5 mod 17 = 15, core latency 10 -> done 11 cycles after grant.
    single("single", 1'b0, 8'd3, 8'd5, 8'd17, 10, 8'd15, 1'b0, 11);

    // Fairness: both held for 6 ops from reset.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    core_lat = 2;
    a0 = 8'd5; b0 = 8'd6; a1 = 8'd7; b1 = 8'd8; m = 8'd23;
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin
        gq.push_back('{2'b01, 8'd5, 8'd6, 8'd23});
        rq.push_back('{2'b01, 8'd7, 1'b0});
      end else begin
        gq.push_back('{2'b10, 8'd7, 8'd8, 8'd23});
        rq.push_back('{2'b10, 8'd10, 1'b0});
      end
    end
    req0 = 1'b1; req1 = 1'b1;
    ng = 0; nd = 0; lastg = 0;
    for (int i = 0; i < 200 && nd < 6; i++) begin
      tick();
      if (gnt0 || gnt1) begin
        ng++;
        // mul_done at g+lat, done at g+lat+1, IDLE at g+lat+2, next grant at g+lat+3.
        if (ng > 1) check("fair_gnt_gap", cyc - lastg, 5);
        lastg = cyc;
        if (ng == 6) begin req0 = 1'b0; req1 = 1'b0; end
      end
      if (done0 || done1) nd++;
    end
    check("fair_six_done", nd, 6);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();
    check("fair_no_extra_gnt", ng, 6);

    // Watchdog: core never finishes -> err, result 0 at WAIT entry + TIMEOUT.
    single("timeout", 1'b0, 8'd3, 8'd5, 8'd17, 0, 8'd0, 1'b1, TO + 1);
    // mul_done on the final watchdog count wins.
    single("timeout_edge", 1'b0, 8'd3, 8'd5, 8'd17, TO, 8'd15, 1'b0, TO + 1);

    // Reset 5 cycles into WAIT: no done for the aborted op.
    core_lat = 0;
    a0 = 8'd3; b0 = 8'd5; m = 8'd17;
    gq.push_back('{2'b01, 8'd3, 8'd5, 8'd17});
    req0 = 1'b1;
    tick();
    g = cyc;
    req0 = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    reset = 1'b1;
    tick();
    check_all_zero("rst_in_wait");
    reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("rst_in_wait_idle", busy, 1'b0);
    single("after_rst_req1", 1'b1, 8'd4, 8'd5, 8'd11, 2, 8'd9, 1'b0, 3);
    core_lat = 2;
    a0 = 8'd2; b0 = 8'd3; a1 = 8'd4; b1 = 8'd5; m = 8'd11;
    gq.push_back('{2'b01, 8'd2, 8'd3, 8'd11});
    rq.push_back('{2'b01, 8'd6, 1'b0});
    req0 = 1'b1; req1 = 1'b1;
    tick();
    check("after_rst_both_gnt0", {gnt1, gnt0}, 2'b01);
    req0 = 1'b0; req1 = 1'b0;
    wait_done("after_rst_both", 100, d);
    tick();
    tick();

    // Operand isolation: inputs change right after the grant.
    core_lat = 1;
    a0 = 8'd9; b0 = 8'd10; m = 8'd29;
    gq.push_back('{2'b01, 8'd9, 8'd10, 8'd29});
    rq.push_back('{2'b01, 8'd3, 1'b0});
    req0 = 1'b1;
    tick();
    check("iso_gnt0", gnt0, 1'b1);
    req0 = 1'b0;
    tick();
    a0 = 8'd1; b0 = 8'd1; m = 8'd2;
    check("iso_ops_g1", {mul_a, mul_b, mul_m}, {8'd9, 8'd10, 8'd29});
    tick();
    check("iso_done0_g2", done0, 1'b1);
    check("iso_ops_g2", {mul_a, mul_b, mul_m}, {8'd9, 8'd10, 8'd29});
    tick();
    tick();

    check("gq_drained", gq.size(), 0);
    check("rq_drained", rq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
